// File: rtl/uart_pkt_wrapper.sv
// Packet layer over a byte UART: assembles CMD_BYTES-byte commands (MSB first) with
// inter-byte timeout and backpressure, and serialises RESP_BYTES-byte responses.
module uart_pkt_wrapper #(
  parameter int CMD_BYTES   = 2,
  parameter int RESP_BYTES  = 1,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    clr_rx_rdy,
  output logic                    cmd_rdy,
  output logic [8*CMD_BYTES-1:0]  cmd,
  input  logic                    clr_cmd_rdy,
  output logic                    timeout_err,
  input  logic                    send_resp,
  input  logic [8*RESP_BYTES-1:0] resp,
  output logic                    resp_busy,
  output logic                    resp_done,
  output logic                    trmt,
  output logic [7:0]              tx_data,
  input  logic                    tx_done
);

  // state   | meaning
  // TX_IDLE | no response in flight, waiting for send_resp
  // TX_LOAD | one-cycle trmt strobe for the current byte
  // TX_WAIT | UART busy with the current byte, waiting for tx_done

  localparam int CW = 8 * CMD_BYTES;
  localparam int RW = 8 * RESP_BYTES;
  localparam int BW = $clog2(CMD_BYTES + 1);
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int IW = (RESP_BYTES > 1) ? $clog2(RESP_BYTES) : 1;

  logic [BW-1:0]  byte_cnt;
  logic [TW-1:0]  to_cnt;
  logic           capture;
  logic           last_byte;
  logic           to_hit;
  logic [CW+7:0]  cmd_shift;

  assign capture   = rx_rdy & ~cmd_rdy & ~clr_rx_rdy;
  assign last_byte = (byte_cnt == BW'(CMD_BYTES - 1));
  assign cmd_shift = {cmd, rx_data};
  // The counter only runs mid-packet, so a single-byte command can never time out.
  assign to_hit    = (TIMEOUT_CYC > 0) && (byte_cnt != '0) &&
                     ((to_cnt + TW'(1)) == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_rx_rdy  <= 1'b0;
      cmd_rdy     <= 1'b0;
      cmd         <= '0;
      timeout_err <= 1'b0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
    end else begin
      clr_rx_rdy  <= capture;
      timeout_err <= 1'b0;
      if (capture) begin
        cmd    <= cmd_shift[CW-1:0];
        to_cnt <= '0;
        if (last_byte) begin
          byte_cnt <= '0;
          cmd_rdy  <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + BW'(1);
        end
      end else begin
        if (cmd_rdy && clr_cmd_rdy)
          cmd_rdy <= 1'b0;
        if (to_hit) begin
          byte_cnt    <= '0;
          to_cnt      <= '0;
          timeout_err <= 1'b1;
        end else if (byte_cnt != '0) begin
          to_cnt <= to_cnt + TW'(1);
        end else begin
          to_cnt <= '0;
        end
      end
    end
  end

  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT} tx_state_t;

  tx_state_t      state, state_nxt;
  logic [RW-1:0]  shreg;
  logic [IW-1:0]  idx;
  logic           accept, advance, finish;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    trmt      = 1'b0;
    case (state)
      TX_IDLE: begin
        if (send_resp) begin
          accept    = 1'b1;
          state_nxt = TX_LOAD;
        end
      end
      TX_LOAD: begin
        trmt      = 1'b1;
        state_nxt = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_done) begin
          if (idx == IW'(RESP_BYTES - 1)) begin
            finish    = 1'b1;
            state_nxt = TX_IDLE;
          end else begin
            advance   = 1'b1;
            state_nxt = TX_LOAD;
          end
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TX_IDLE;
      shreg     <= '0;
      idx       <= '0;
      resp_busy <= 1'b0;
      resp_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      resp_done <= finish;
      if (accept) begin
        shreg     <= resp;
        idx       <= '0;
        resp_busy <= 1'b1;
      end
      if (advance) begin
        shreg <= shreg << 8;
        idx   <= idx + IW'(1);
      end
      if (finish)
        resp_busy <= 1'b0;
    end
  end

  // Shifting left keeps the byte being sent in the top lane; it stays put after the last byte.
  assign tx_data = shreg[RW-1 -: 8];

endmodule
